// File: rtl/szg_i2s2_pmod_tx_phy.sv
// I2S transmit PHY for the PMOD-I2S2 line-out DAC.
// One free-running counter derives MCLK/SCLK/LRCK; one stereo pair is shifted out per 512-clk frame.
module szg_i2s2_pmod_tx_phy #(
   parameter int DATA_WIDTH = 24
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] l_channel,
   input  logic [DATA_WIDTH-1:0] r_channel,
   output logic                  tx_mclk,
   output logic                  tx_lrck,
   output logic                  tx_sclk,
   output logic                  tx_sdout,
   output logic                  frame_start,
   output logic                  underflow
);

   logic [8:0]            cnt;
   logic [DATA_WIDTH-1:0] hold_l;
   logic [DATA_WIDTH-1:0] hold_r;
   logic                  hold_valid;
   logic                  started;
   logic [63:0]           shift;
   logic [63:0]           frame;
   logic [31:0]           slot_l;
   logic [31:0]           slot_r;
   logic                  load;
   logic                  sclk_fall;
   logic                  accept;

   assign load      = (cnt == 9'd511);
   assign sclk_fall = (cnt[2:0] == 3'b111);
   assign accept    = in_valid && in_ready;

   // Clock outputs are raw counter bits, so they come straight from flops.
   assign tx_mclk = cnt[0];
   assign tx_sclk = cnt[2];
   assign tx_lrck = cnt[8];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 9'd1;
      end
   end

   // Each 32-bit slot is a leading zero, the sample MSB-first, then zero padding.
   always_comb begin
      slot_l = '0;
      slot_r = '0;
      if (hold_valid) begin
         slot_l = 32'(hold_l) << (31 - DATA_WIDTH);
         slot_r = 32'(hold_r) << (31 - DATA_WIDTH);
      end
      frame = {slot_l, slot_r};
   end

   // in_ready is held low on the accept edge itself so a second pair can never overwrite the first.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hold_l     <= '0;
         hold_r     <= '0;
         hold_valid <= 1'b0;
         in_ready   <= 1'b0;
      end else begin
         if (accept) begin
            hold_l <= l_channel;
            hold_r <= r_channel;
         end
         hold_valid <= accept || (hold_valid && !load);
         in_ready   <= !hold_valid && !accept;
      end
   end

   // The load edge is also an SCLK falling edge; the frame replaces the shifter there.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         shift       <= '0;
         tx_sdout    <= 1'b0;
         frame_start <= 1'b0;
         underflow   <= 1'b0;
         started     <= 1'b0;
      end else begin
         frame_start <= load;
         underflow   <= load && !hold_valid && started;
         if (load) begin
            started  <= 1'b1;
            tx_sdout <= frame[63];
            shift    <= frame << 1;
         end else if (sclk_fall) begin
            tx_sdout <= shift[63];
            shift    <= shift << 1;
         end
      end
   end

endmodule
